doorlock_supervisor: RTL and testbench



---
 rtl/doorlock_pkg.sv | 19 +
 rtl/doorlock_lock_timer.sv | 86 ++++++++
 rtl/doorlock_supervisor.sv | 158 +++++++++++++++
 tb/tb_doorlock_supervisor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doorlock_pkg.sv
// Shared types and constants for the door-lock supervisor and its lockout timer.
// Pure declarations: no logic, no latency, no flow control.
package doorlock_pkg;

    typedef enum logic [1:0] {
        ST_RUN1  = 2'd0,
        ST_RUN2  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    localparam logic [1:0] DISP_FSM1 = 2'd0;
    localparam logic [1:0] DISP_FSM2 = 2'd1;
    localparam logic [1:0] DISP_LOCK = 2'd2;

    localparam logic [9:0] LED_ALL_ON  = 10'h3FF;
    localparam logic [9:0] LED_ALL_OFF = 10'h000;

endpackage

// File: rtl/doorlock_lock_timer.sv
// Lockout timer: one-second prescaler, seconds countdown and LED blink divider.
// Registered outputs; start restarts everything; done is a same-cycle pulse on the final tick.
module lock_timer
    import doorlock_pkg::*;
#(
    parameter int SEC_CYCLES   = 50_000_000,
    parameter int LOCK_SECS    = 5,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic       done_o,
    output logic       active_o,
    output logic [3:0] secs_o,
    output logic [9:0] led_o
);

    localparam int PW = (SEC_CYCLES   > 1) ? $clog2(SEC_CYCLES)   : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic          active_q, active_d;
    logic [3:0]    secs_q, secs_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [9:0]    led_q, led_d;
    logic          tick;
    logic          blink_wrap;

    assign tick       = active_q && (presc_q == PW'(SEC_CYCLES - 1));
    assign blink_wrap = (blink_q == BW'(BLINK_CYCLES - 1));
    assign done_o     = tick && (secs_q == 4'd1);

    always_comb begin
        active_d = active_q;
        secs_d   = secs_q;
        presc_d  = presc_q;
        blink_d  = blink_q;
        led_d    = led_q;
        if (start_i) begin
            active_d = 1'b1;
            secs_d   = 4'(LOCK_SECS);
            presc_d  = '0;
            blink_d  = '0;
            led_d    = LED_ALL_ON;
        end else if (active_q) begin
            if (done_o) begin
                active_d = 1'b0;
                secs_d   = 4'd0;
                presc_d  = '0;
                blink_d  = '0;
                led_d    = LED_ALL_OFF;
            end else begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    secs_d = secs_q - 4'd1;
                end
                blink_d = blink_wrap ? '0 : blink_q + BW'(1);
                if (blink_wrap) begin
                    led_d = ~led_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            secs_q   <= 4'd0;
            presc_q  <= '0;
            blink_q  <= '0;
            led_q    <= LED_ALL_OFF;
        end else begin
            active_q <= active_d;
            secs_q   <= secs_d;
            presc_q  <= presc_d;
            blink_q  <= blink_d;
            led_q    <= led_d;
        end
    end

    assign active_o = active_q;
    assign secs_o   = secs_q;
    assign led_o    = led_q;

endmodule

// File: rtl/doorlock_supervisor.sv
// Door-lock sequencer: grants FSM1/FSM2 ownership, defers switches until idle, enforces lockout.
// All outputs registered; inputs forwarded with 1-cycle latency; mode changes land 3 cycles after mode_req.
module doorlock_supervisor
    import doorlock_pkg::*;
#(
    parameter int SEC_CYCLES   = 50_000_000,
    parameter int LOCK_SECS    = 5,
    parameter int MAX_FAIL     = 3,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_req,
    input  logic [7:0] sw_edge,
    input  logic       btn_start,
    input  logic       btn_end,
    input  logic       fsm1_busy,
    input  logic       fsm2_busy,
    input  logic       fsm1_done,
    input  logic       fsm1_pass,
    output logic       fsm1_en,
    output logic       fsm2_en,
    output logic [7:0] sw_edge_o,
    output logic       btn_start_o,
    output logic       btn_end_o,
    output logic [1:0] disp_sel,
    output logic [3:0] lock_secs,
    output logic [1:0] fail_cnt,
    output logic       locked,
    output logic       led_ovr_en,
    output logic [9:0] led_override
);

    logic       mode_s1_q, m_sync_q;
    state_t     state_q, state_d;
    logic       owner_q, owner_d;   // 0 = FSM1 owns, 1 = FSM2 owns
    logic [1:0] fail_q, fail_d;
    logic       fsm1_en_q, fsm1_en_d, fsm2_en_q, fsm2_en_d;
    logic [1:0] disp_q, disp_d;
    logic       locked_q;
    logic [7:0] sw_q;
    logic       bs_prev_q, be_prev_q, bs_pulse_q, be_pulse_q;
    logic       owner_busy, fsm1_owns, fwd_en;
    logic       tmr_start, tmr_done;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        fail_d     = fail_q;
        tmr_start  = 1'b0;
        owner_busy = owner_q ? fsm2_busy : fsm1_busy;
        fsm1_owns  = (state_q != ST_LOCK) && !owner_q;

        case (state_q)
            ST_RUN1, ST_RUN2, ST_DRAIN: begin
                if (m_sync_q != owner_q) begin
                    if (owner_busy) begin
                        state_d = ST_DRAIN;
                    end else begin
                        owner_d = m_sync_q;
                        state_d = m_sync_q ? ST_RUN2 : ST_RUN1;
                    end
                end else begin
                    state_d = owner_q ? ST_RUN2 : ST_RUN1;
                end
            end
            ST_LOCK: begin
                if (tmr_done) begin
                    owner_d = m_sync_q;
                    state_d = m_sync_q ? ST_RUN2 : ST_RUN1;
                    fail_d  = 2'd0;
                end
            end
            default: begin
                state_d = ST_RUN1;
                owner_d = 1'b0;
            end
        endcase

        // A lockout-triggering failure overrides any switch decided above.
        if (fsm1_owns && fsm1_done) begin
            if (fsm1_pass) begin
                fail_d = 2'd0;
            end else if (fail_q == 2'(MAX_FAIL - 1)) begin
                fail_d    = 2'(MAX_FAIL);
                state_d   = ST_LOCK;
                owner_d   = owner_q;
                tmr_start = 1'b1;
            end else begin
                fail_d = fail_q + 2'd1;
            end
        end

        fwd_en    = (state_d != ST_LOCK);
        fsm1_en_d = fwd_en && !owner_d;
        fsm2_en_d = fwd_en && owner_d;
        disp_d    = !fwd_en ? DISP_LOCK : (owner_d ? DISP_FSM2 : DISP_FSM1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_q  <= 1'b0;
            m_sync_q   <= 1'b0;
            state_q    <= ST_RUN1;
            owner_q    <= 1'b0;
            fail_q     <= 2'd0;
            fsm1_en_q  <= 1'b1;
            fsm2_en_q  <= 1'b0;
            disp_q     <= DISP_FSM1;
            locked_q   <= 1'b0;
            sw_q       <= 8'd0;
            bs_prev_q  <= 1'b0;
            be_prev_q  <= 1'b0;
            bs_pulse_q <= 1'b0;
            be_pulse_q <= 1'b0;
        end else begin
            mode_s1_q  <= mode_req;
            m_sync_q   <= mode_s1_q;
            state_q    <= state_d;
            owner_q    <= owner_d;
            fail_q     <= fail_d;
            fsm1_en_q  <= fsm1_en_d;
            fsm2_en_q  <= fsm2_en_d;
            disp_q     <= disp_d;
            locked_q   <= (state_d == ST_LOCK);
            sw_q       <= fwd_en ? sw_edge : 8'd0;
            // Edge history runs through lockout so a held press never fires on exit.
            bs_prev_q  <= btn_start;
            be_prev_q  <= btn_end;
            bs_pulse_q <= fwd_en && btn_start && !bs_prev_q;
            be_pulse_q <= fwd_en && btn_end && !be_prev_q;
        end
    end

    lock_timer #(
        .SEC_CYCLES  (SEC_CYCLES),
        .LOCK_SECS   (LOCK_SECS),
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_lock_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (tmr_start),
        .done_o  (tmr_done),
        .active_o(led_ovr_en),
        .secs_o  (lock_secs),
        .led_o   (led_override)
    );

    assign fsm1_en     = fsm1_en_q;
    assign fsm2_en     = fsm2_en_q;
    assign sw_edge_o   = sw_q;
    assign btn_start_o = bs_pulse_q;
    assign btn_end_o   = be_pulse_q;
    assign disp_sel    = disp_q;
    assign fail_cnt    = fail_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_doorlock_supervisor.sv
// Randomized bench for doorlock_supervisor against a cycle-level behavioural model.
module tb_doorlock_supervisor;

    localparam int SC = 10;
    localparam int LK = 3;
    localparam int MF = 3;
    localparam int BL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_req;
    logic [7:0] sw_edge;
    logic       btn_start, btn_end;
    logic       fsm1_busy, fsm2_busy;
    logic       fsm1_done, fsm1_pass;
    logic       fsm1_en, fsm2_en;
    logic [7:0] sw_edge_o;
    logic       btn_start_o, btn_end_o;
    logic [1:0] disp_sel;
    logic [3:0] lock_secs;
    logic [1:0] fail_cnt;
    logic       locked;
    logic       led_ovr_en;
    logic [9:0] led_override;

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner is 1 or 2, lockout tracked as elapsed cycles since entry.
    int   m_owner;
    bit   m_locked;
    int   m_fail;
    int   m_age;
    bit   m_bs_prev, m_be_prev;
    bit   mode_hist[$];
    int   e_sw, e_bs, e_be;

    always #5 clk = ~clk;

    doorlock_supervisor #(
        .SEC_CYCLES  (SC),
        .LOCK_SECS   (LK),
        .MAX_FAIL    (MF),
        .BLINK_CYCLES(BL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_req    (mode_req),
        .sw_edge     (sw_edge),
        .btn_start   (btn_start),
        .btn_end     (btn_end),
        .fsm1_busy   (fsm1_busy),
        .fsm2_busy   (fsm2_busy),
        .fsm1_done   (fsm1_done),
        .fsm1_pass   (fsm1_pass),
        .fsm1_en     (fsm1_en),
        .fsm2_en     (fsm2_en),
        .sw_edge_o   (sw_edge_o),
        .btn_start_o (btn_start_o),
        .btn_end_o   (btn_end_o),
        .disp_sel    (disp_sel),
        .lock_secs   (lock_secs),
        .fail_cnt    (fail_cnt),
        .locked      (locked),
        .led_ovr_en  (led_ovr_en),
        .led_override(led_override)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = 1;
        m_locked  = 1'b0;
        m_fail    = 0;
        m_age     = 0;
        m_bs_prev = 1'b0;
        m_be_prev = 1'b0;
        mode_hist = '{1'b0, 1'b0};
        e_sw = 0;
        e_bs = 0;
        e_be = 0;
    endtask

    // The mode seen by the sequencer is the raw level from two clock edges ago.
    task automatic model_step();
        bit m;
        int want;
        m    = mode_hist[0];
        want = m ? 2 : 1;
        if (m_locked) begin
            m_age++;
            if (m_age == LK * SC) begin
                m_locked = 1'b0;
                m_owner  = want;
                m_fail   = 0;
            end
        end else begin
            if (m_owner == 1 && fsm1_done) begin
                if (fsm1_pass) begin
                    m_fail = 0;
                end else begin
                    m_fail++;
                    if (m_fail == MF) begin
                        m_locked = 1'b1;
                        m_age    = 0;
                    end
                end
            end
            if (!m_locked && want != m_owner) begin
                if (!((m_owner == 1) ? fsm1_busy : fsm2_busy)) m_owner = want;
            end
        end
        e_sw = m_locked ? 0 : int'(sw_edge);
        e_bs = (btn_start && !m_bs_prev && !m_locked) ? 1 : 0;
        e_be = (btn_end && !m_be_prev && !m_locked) ? 1 : 0;
        m_bs_prev = btn_start;
        m_be_prev = btn_end;
        mode_hist.push_back(mode_req);
        void'(mode_hist.pop_front());
    endtask

    task automatic check_all();
        int exp_secs, exp_led;
        exp_secs = m_locked ? (LK - m_age / SC) : 0;
        exp_led  = (m_locked && ((m_age / BL) % 2 == 0)) ? 'h3FF : 0;
        check("fsm1_en", int'(fsm1_en), (!m_locked && m_owner == 1) ? 1 : 0);
        check("fsm2_en", int'(fsm2_en), (!m_locked && m_owner == 2) ? 1 : 0);
        check("en_exclusive", int'(fsm1_en & fsm2_en), 0);
        check("disp_sel", int'(disp_sel), m_locked ? 2 : m_owner - 1);
        check("locked", int'(locked), m_locked ? 1 : 0);
        check("lock_secs", int'(lock_secs), exp_secs);
        check("led_ovr_en", int'(led_ovr_en), m_locked ? 1 : 0);
        check("led_override", int'(led_override), exp_led);
        check("sw_edge_o", int'(sw_edge_o), e_sw);
        check("btn_start_o", int'(btn_start_o), e_bs);
        check("btn_end_o", int'(btn_end_o), e_be);
        if (!m_locked) check("fail_cnt", int'(fail_cnt), m_fail);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sw_edge = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
            cycle();
        end
        sw_edge = 8'd0;
    endtask

    task automatic pulse_done(input bit pass);
        fsm1_done = 1'b1;
        fsm1_pass = pass;
        sw_edge   = 8'($urandom);
        cycle();
        fsm1_done = 1'b0;
        fsm1_pass = 1'($urandom);
        sw_edge   = 8'd0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        run(3);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        mode_req = 1'b0; sw_edge = 8'd0;
        btn_start = 1'b0; btn_end = 1'b0;
        fsm1_busy = 1'b0; fsm2_busy = 1'b0;
        fsm1_done = 1'b0; fsm1_pass = 1'b0;
        @(negedge clk);
        apply_reset();

        // Reset release and a single forwarded switch edge.
        run(2);
        sw_edge = 8'h04;
        cycle();
        sw_edge = 8'h00;
        cycle();
        check("sw_edge_o_idle", int'(sw_edge_o), 0);

        // Idle switch to FSM2 and back.
        mode_req = 1'b1;
        run(6);
        mode_req = 1'b0;
        run(6);

        // Drain: FSM1 busy for 20 cycles, then release.
        fsm1_busy = 1'b1;
        mode_req  = 1'b1;
        run(20);
        fsm1_busy = 1'b0;
        run(5);
        mode_req = 1'b0;
        run(6);

        // Revert mid-drain keeps FSM1.
        fsm1_busy = 1'b1;
        mode_req  = 1'b1;
        run(6);
        mode_req = 1'b0;
        run(4);
        fsm1_busy = 1'b0;
        run(4);

        // Three failures, full lockout with buttons toggling.
        pulse_done(1'b0); run(3);
        pulse_done(1'b0); run(3);
        pulse_done(1'b0);
        btn_end = 1'b1; run(5); btn_end = 1'b0;
        run(LK * SC);

        // fail, fail, pass clears the count.
        pulse_done(1'b0); run(2);
        pulse_done(1'b0); run(2);
        pulse_done(1'b1); run(2);

        // Third failure coinciding with a mode change: lockout first, FSM2 at exit.
        pulse_done(1'b0); run(2);
        pulse_done(1'b0); run(1);
        mode_req = 1'b1;
        cycle();
        cycle();
        pulse_done(1'b0);
        run(LK * SC + 3);
        mode_req = 1'b0;
        run(6);

        // Button held across lockout exit, released afterwards.
        pulse_done(1'b0); run(1);
        pulse_done(1'b0); run(1);
        pulse_done(1'b0);
        run(4);
        btn_start = 1'b1;
        run(LK * SC);
        btn_start = 1'b0;
        run(3);
        btn_start = 1'b1;
        run(3);
        btn_start = 1'b0;

        // Asynchronous reset in the middle of a lockout.
        pulse_done(1'b0); run(1);
        pulse_done(1'b0); run(1);
        pulse_done(1'b0);
        run(12);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        run(2);
        rst_n = 1'b1;
        run(3);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) mode_req = ~mode_req;
            if ($urandom_range(0, 7) == 0) fsm1_busy = ~fsm1_busy;
            if ($urandom_range(0, 7) == 0) fsm2_busy = ~fsm2_busy;
            if ($urandom_range(0, 9) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 9) == 0) btn_end = ~btn_end;
            fsm1_done = ($urandom_range(0, 5) == 0);
            fsm1_pass = ($urandom_range(0, 3) == 0);
            sw_edge   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
            cycle();
        end
        fsm1_done = 1'b0;
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
